// File: rtl/des_pkg.sv
// Shared DES datapath constants for the decrypt front end.
//   DES_BLOCK_W     : bits per cipher block
//   DES_BYTE_W      : bits per stream byte
//   DES_BLOCK_BYTES : bytes per cipher block
package des_pkg;

  localparam int unsigned DES_BLOCK_W     = 64;
  localparam int unsigned DES_BYTE_W      = 8;
  localparam int unsigned DES_BLOCK_BYTES = DES_BLOCK_W / DES_BYTE_W;

endpackage

// File: rtl/des_block_hold_reg.sv
// Single-entry valid/ready output register holding one cipher block and its last flag.
// Loaded only when free (empty, or being drained this cycle), so a new block can replace
// the old one at the edge it is consumed.
//   clk, rst_n                 : clock, synchronous active-low reset
//   load, load_data, load_last : write a new block (caller guarantees free=1)
//   data, valid, last          : held block towards downstream
//   ready                      : downstream takes the block this cycle
//   free                       : register may be loaded this cycle
module des_block_hold_reg
  import des_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   load,
  input  logic [DES_BLOCK_W-1:0] load_data,
  input  logic                   load_last,
  output logic [DES_BLOCK_W-1:0] data,
  output logic                   valid,
  output logic                   last,
  input  logic                   ready,
  output logic                   free
);

  logic [DES_BLOCK_W-1:0] data_q;
  logic                   valid_q;
  logic                   last_q;

  assign free  = !valid_q || ready;
  assign data  = data_q;
  assign valid = valid_q;
  assign last  = last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (load) begin
      data_q  <= load_data;
      last_q  <= load_last;
      valid_q <= 1'b1;
    end else if (ready) begin
      // Drained with no replacement; data and last keep their old values.
      valid_q <= 1'b0;
    end
  end

endmodule

// File: rtl/des_cipher_block_packer.sv
// Packs a ciphertext byte stream into 64-bit DES blocks. An assembly shift register fills
// while the hold register presents the previous block downstream. A message that ends on a
// partial block is discarded, flagged with a one-cycle frag_error pulse and counted in the
// saturating dropped_bytes counter.
//   clk, rst_n                         : clock, synchronous active-low reset
//   byte_in, byte_valid, byte_last     : input byte stream
//   byte_ready                         : byte accepted this cycle
//   block_out, block_valid, block_last : assembled block stream
//   block_ready                        : downstream takes block this cycle
//   frag_error                         : pulse, message ended on a partial block
//   dropped_bytes                      : saturating count of discarded fragment bytes
module des_cipher_block_packer
  import des_pkg::*;
#(
  parameter int unsigned BLOCK_BYTES = DES_BLOCK_BYTES,
  parameter int unsigned MSB_FIRST   = 1,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DES_BYTE_W-1:0]  byte_in,
  input  logic                   byte_valid,
  input  logic                   byte_last,
  output logic                   byte_ready,
  output logic [DES_BLOCK_W-1:0] block_out,
  output logic                   block_valid,
  output logic                   block_last,
  input  logic                   block_ready,
  output logic                   frag_error,
  output logic [CNT_W-1:0]       dropped_bytes
);

  localparam int unsigned FillW = $clog2(BLOCK_BYTES + 1);
  localparam logic [FillW-1:0] Full    = FillW'(BLOCK_BYTES);
  localparam logic [FillW-1:0] LastIdx = FillW'(BLOCK_BYTES - 1);

  logic [FillW-1:0]       cnt_q, cnt_d;
  logic [DES_BLOCK_W-1:0] asm_q, asm_d, shifted;
  logic                   asm_last_q, asm_last_d;
  logic                   frag_q, frag_d;
  logic [CNT_W-1:0]       dropped_q, dropped_d;
  logic [CNT_W:0]         drop_sum;

  logic                   load;
  logic [DES_BLOCK_W-1:0] load_data;
  logic                   load_last;
  logic                   out_free;
  logic                   byte_fire;

  // cnt_q == Full means the assembly register holds a finished block queued behind the
  // output register; no further bytes are taken until it moves.
  assign byte_ready    = rst_n && (cnt_q != Full);
  assign byte_fire     = byte_valid && byte_ready;
  assign frag_error    = frag_q;
  assign dropped_bytes = dropped_q;

  always_comb begin
    shifted = asm_q;
    if (MSB_FIRST != 0) begin
      shifted = {asm_q[DES_BLOCK_W-DES_BYTE_W-1:0], byte_in};
    end else begin
      shifted = {byte_in, asm_q[DES_BLOCK_W-1:DES_BYTE_W]};
    end
  end

  // Fragment length is cnt_q + 1, including the byte carrying byte_last.
  assign drop_sum = {1'b0, dropped_q} + (CNT_W + 1)'(cnt_q) + (CNT_W + 1)'(1);

  always_comb begin
    cnt_d      = cnt_q;
    asm_d      = asm_q;
    asm_last_d = asm_last_q;
    frag_d     = 1'b0;
    dropped_d  = dropped_q;
    load       = 1'b0;
    load_data  = asm_q;
    load_last  = asm_last_q;

    if (cnt_q == Full) begin
      if (out_free) begin
        load  = 1'b1;
        cnt_d = '0;
      end
    end else if (byte_fire) begin
      if (cnt_q == LastIdx) begin
        if (out_free) begin
          // Completed block bypasses the assembly register straight into the output.
          load      = 1'b1;
          load_data = shifted;
          load_last = byte_last;
          cnt_d     = '0;
        end else begin
          asm_d      = shifted;
          asm_last_d = byte_last;
          cnt_d      = Full;
        end
      end else if (byte_last) begin
        cnt_d     = '0;
        frag_d    = 1'b1;
        dropped_d = drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
      end else begin
        asm_d = shifted;
        cnt_d = cnt_q + FillW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      asm_q      <= '0;
      asm_last_q <= 1'b0;
      frag_q     <= 1'b0;
      dropped_q  <= '0;
    end else begin
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      asm_last_q <= asm_last_d;
      frag_q     <= frag_d;
      dropped_q  <= dropped_d;
    end
  end

  des_block_hold_reg u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .load_last (load_last),
    .data      (block_out),
    .valid     (block_valid),
    .last      (block_last),
    .ready     (block_ready),
    .free      (out_free)
  );

endmodule
